// File: rtl/pipeline_mem.sv
// MEM stage: EX/MEM register, single-outstanding data-memory access, store lane packing and load extension.
// Non-memory ops retire in one cycle; stallM_o holds upstream until a store is granted or a load response returns.
module pipeline_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic        validE_i,
  input  logic        regWriteEnE_i,
  input  logic [1:0]  resultSrcE_i,
  input  logic        memReadE_i,
  input  logic        memWriteE_i,
  input  logic [2:0]  memFunct3E_i,
  input  logic [31:0] aluResultE_i,
  input  logic [31:0] writeDataE_i,
  input  logic [31:0] pcPlus4E_i,
  input  logic [31:0] extendedImmE_i,
  input  logic [4:0]  rdE_i,
  output logic        stallM_o,
  output logic        dmemReq_o,
  output logic        dmemWe_o,
  output logic [31:0] dmemAddr_o,
  output logic [3:0]  dmemWstrb_o,
  output logic [31:0] dmemWdata_o,
  input  logic        dmemGnt_i,
  input  logic        dmemRvalid_i,
  input  logic [31:0] dmemRdata_i,
  output logic        regWriteEnM_o,
  output logic [1:0]  resultSrcM_o,
  output logic [31:0] aluResultM_o,
  output logic [31:0] memReadDataM_o,
  output logic [31:0] pcPlus4M_o,
  output logic [31:0] extendedImmM_o,
  output logic [4:0]  rdM_o,
  output logic        misalignM_o
);

  typedef enum logic {IDLE, WAIT_R} state_t;

  typedef struct packed {
    logic        valid;
    logic        reg_we;
    logic [1:0]  result_src;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rd;
  } stage_t;

  stage_t      stage_q, stage_d;
  state_t      state_q, state_d;
  logic        memop, misal, access, done, req;
  logic [1:0]  a;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign a     = stage_q.alu[1:0];
  assign memop = stage_q.mem_rd | stage_q.mem_wr;

  // Illegal widths are folded into misalign so they retire as bubbles too.
  always_comb begin
    case (stage_q.funct3)
      3'b000, 3'b100: misal = 1'b0;
      3'b001, 3'b101: misal = a[0];
      3'b010:         misal = (a != 2'b00);
      default:        misal = 1'b1;
    endcase
  end

  assign access = stage_q.valid & memop & ~misal;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          req = 1'b1;
          if (dmemGnt_i) begin
            if (stage_q.mem_wr) done = 1'b1;
            else                state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (dmemRvalid_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stallM_o = access & ~done;

  always_comb begin
    stage_d = stage_q;
    if (!stallM_o) begin
      stage_d.valid      = validE_i;
      stage_d.reg_we     = regWriteEnE_i;
      stage_d.result_src = resultSrcE_i;
      stage_d.mem_rd     = memReadE_i;
      stage_d.mem_wr     = memWriteE_i;
      stage_d.funct3     = memFunct3E_i;
      stage_d.alu        = aluResultE_i;
      stage_d.wdata      = writeDataE_i;
      stage_d.pc4        = pcPlus4E_i;
      stage_d.imm        = extendedImmE_i;
      stage_d.rd         = rdE_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
      state_q <= IDLE;
    end else begin
      stage_q <= stage_d;
      state_q <= state_d;
    end
  end

  assign dmemReq_o  = req;
  assign dmemWe_o   = stage_q.mem_wr;
  assign dmemAddr_o = {stage_q.alu[31:2], 2'b00};

  always_comb begin
    dmemWdata_o = '0;
    dmemWstrb_o = '0;
    if (stage_q.mem_wr) begin
      case (stage_q.funct3[1:0])
        2'b00: begin
          dmemWdata_o = {4{stage_q.wdata[7:0]}};
          dmemWstrb_o = 4'b0001 << a;
        end
        2'b01: begin
          dmemWdata_o = {2{stage_q.wdata[15:0]}};
          dmemWstrb_o = 4'b0011 << a;
        end
        default: begin
          dmemWdata_o = stage_q.wdata;
          dmemWstrb_o = 4'b1111;
        end
      endcase
    end
  end

  // Halfword lane only needs addr[1]; addr[0]=1 halfword loads never retire.
  always_comb begin
    case (a)
      2'd0:    ld_byte = dmemRdata_i[7:0];
      2'd1:    ld_byte = dmemRdata_i[15:8];
      2'd2:    ld_byte = dmemRdata_i[23:16];
      default: ld_byte = dmemRdata_i[31:24];
    endcase
    ld_half = a[1] ? dmemRdata_i[31:16] : dmemRdata_i[15:0];
  end

  always_comb begin
    memReadDataM_o = '0;
    if (stage_q.valid & stage_q.mem_rd) begin
      case (stage_q.funct3)
        3'b000:  memReadDataM_o = {{24{ld_byte[7]}}, ld_byte};
        3'b001:  memReadDataM_o = {{16{ld_half[15]}}, ld_half};
        3'b100:  memReadDataM_o = {24'b0, ld_byte};
        3'b101:  memReadDataM_o = {16'b0, ld_half};
        default: memReadDataM_o = dmemRdata_i;
      endcase
    end
  end

  assign misalignM_o    = stage_q.valid & memop & misal;
  assign regWriteEnM_o  = stage_q.valid & stage_q.reg_we & ~stallM_o & ~misalignM_o;
  assign resultSrcM_o   = stage_q.result_src;
  assign aluResultM_o   = stage_q.alu;
  assign pcPlus4M_o     = stage_q.pc4;
  assign extendedImmM_o = stage_q.imm;
  assign rdM_o          = stage_q.rd;

endmodule

// File: tb/tb_pipeline_mem.sv
// Bench for pipeline_mem: vector table driven through a per-instruction task, write-backs
// checked against a queue of expected results, plus hand sequences for back-to-back and reset cases.
module tb_pipeline_mem;

  logic        clk, reset;
  logic        validE_i, regWriteEnE_i, memReadE_i, memWriteE_i;
  logic [1:0]  resultSrcE_i;
  logic [2:0]  memFunct3E_i;
  logic [31:0] aluResultE_i, writeDataE_i, pcPlus4E_i, extendedImmE_i;
  logic [4:0]  rdE_i;
  logic        stallM_o, dmemReq_o, dmemWe_o;
  logic [31:0] dmemAddr_o, dmemWdata_o;
  logic [3:0]  dmemWstrb_o;
  logic        dmemGnt_i, dmemRvalid_i;
  logic [31:0] dmemRdata_i;
  logic        regWriteEnM_o, misalignM_o;
  logic [1:0]  resultSrcM_o;
  logic [31:0] aluResultM_o, memReadDataM_o, pcPlus4M_o, extendedImmM_o;
  logic [4:0]  rdM_o;

  pipeline_mem dut (
    .clk(clk), .reset(reset),
    .validE_i(validE_i), .regWriteEnE_i(regWriteEnE_i), .resultSrcE_i(resultSrcE_i),
    .memReadE_i(memReadE_i), .memWriteE_i(memWriteE_i), .memFunct3E_i(memFunct3E_i),
    .aluResultE_i(aluResultE_i), .writeDataE_i(writeDataE_i), .pcPlus4E_i(pcPlus4E_i),
    .extendedImmE_i(extendedImmE_i), .rdE_i(rdE_i),
    .stallM_o(stallM_o), .dmemReq_o(dmemReq_o), .dmemWe_o(dmemWe_o), .dmemAddr_o(dmemAddr_o),
    .dmemWstrb_o(dmemWstrb_o), .dmemWdata_o(dmemWdata_o),
    .dmemGnt_i(dmemGnt_i), .dmemRvalid_i(dmemRvalid_i), .dmemRdata_i(dmemRdata_i),
    .regWriteEnM_o(regWriteEnM_o), .resultSrcM_o(resultSrcM_o), .aluResultM_o(aluResultM_o),
    .memReadDataM_o(memReadDataM_o), .pcPlus4M_o(pcPlus4M_o), .extendedImmM_o(extendedImmM_o),
    .rdM_o(rdM_o), .misalignM_o(misalignM_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic        vld, we, rdop, wrop;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc4, imm, rdata;
    int          g, r;
    logic        req, mis;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          stalls;
    logic        wb;
    logic [31:0] wbval;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [31:0] val;
  } wb_t;

  wb_t sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Every retiring RF write must match the oldest outstanding expectation.
  always @(negedge clk) begin : wb_mon
    wb_t         e;
    logic [31:0] act;
    if (regWriteEnM_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL wb_unexpected: got write to rd=%0d, expected no write", rdM_o);
      end else begin
        e = sb_q.pop_front();
        case (e.src)
          2'd0:    act = aluResultM_o;
          2'd1:    act = extendedImmM_o;
          2'd2:    act = memReadDataM_o;
          default: act = pcPlus4M_o;
        endcase
        chk("wb_rd", {27'b0, rdM_o}, {27'b0, e.rd});
        chk("wb_src", {30'b0, resultSrcM_o}, {30'b0, e.src});
        chk("wb_val", act, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic drive_e(input vec_t v);
    validE_i       = v.vld;
    regWriteEnE_i  = v.we;
    memReadE_i     = v.rdop;
    memWriteE_i    = v.wrop;
    resultSrcE_i   = v.src;
    memFunct3E_i   = v.f3;
    rdE_i          = v.rd;
    aluResultE_i   = v.alu;
    writeDataE_i   = v.wd;
    pcPlus4E_i     = v.pc4;
    extendedImmE_i = v.imm;
  endtask

  task automatic bubble_e();
    validE_i      = 1'b0;
    regWriteEnE_i = 1'b0;
    memReadE_i    = 1'b0;
    memWriteE_i   = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    int stalls;
    bit fin;
    drive_e(v);
    dmemGnt_i    = 1'b0;
    dmemRvalid_i = 1'b0;
    @(posedge clk); #1;
    if (v.wb) sb_q.push_back('{rd: v.rd, src: v.src, val: v.wbval});
    bubble_e();
    stalls = 0;
    fin    = 1'b0;
    for (int c = 0; c < 20 && !fin; c++) begin
      dmemGnt_i    = (c == v.g);
      dmemRvalid_i = (c == v.r);
      dmemRdata_i  = v.rdata;
      @(negedge clk);
      if (c == 0) chk("misalign", {31'b0, misalignM_o}, {31'b0, v.mis});
      if (v.req && c <= v.g) begin
        chk("req", {31'b0, dmemReq_o}, 32'd1);
        chk("addr", dmemAddr_o, v.addr);
        chk("we", {31'b0, dmemWe_o}, {31'b0, v.wrop});
        if (v.wrop) begin
          chk("wstrb", {28'b0, dmemWstrb_o}, {28'b0, v.wstrb});
          chk("wdata", dmemWdata_o, v.wdata);
        end
      end else if (!v.req || stallM_o) begin
        chk("req_idle", {31'b0, dmemReq_o}, 32'd0);
      end
      if (stallM_o) stalls++;
      else          fin = 1'b1;
      @(posedge clk); #1;
    end
    dmemGnt_i    = 1'b0;
    dmemRvalid_i = 1'b0;
    chk("stall_cycles", stalls, v.stalls);
  endtask

  vec_t vt[17];
  vec_t h;

  initial begin
    //        vld   we    rdop  wrop  src   f3    rd     alu           wd            pc4           imm           rdata         g   r   req   mis   addr          wstrb  wdata         st wb    wbval
    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 5'd5,  32'h00001234, 32'h0,        32'h0,        32'h0,        32'h0,        99, 99, 1'b0, 1'b0, 32'h0,        4'h0,  32'h0,        0, 1'b1, 32'h00001234};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 5'd0,  32'h00001003, 32'hAABBCCDD, 32'h0,        32'h0,        32'h0,        0,  99, 1'b1, 1'b0, 32'h00001000, 4'h8,  32'hDDDDDDDD, 0, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 3'd0, 5'd7,  32'h00002002, 32'h0,        32'h0,        32'h0,        32'h00800000, 0,  3,  1'b1, 1'b0, 32'h00002000, 4'h0,  32'h0,        3, 1'b1, 32'hFFFFFF80};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 3'd5, 5'd8,  32'h00002002, 32'h0,        32'h0,        32'h0,        32'h8001FFFF, 0,  1,  1'b1, 1'b0, 32'h00002000, 4'h0,  32'h0,        1, 1'b1, 32'h00008001};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 3'd2, 5'd9,  32'h00002001, 32'h0,        32'h0,        32'h0,        32'h0,        99, 99, 1'b0, 1'b1, 32'h0,        4'h0,  32'h0,        0, 1'b0, 32'h0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd2, 5'd0,  32'h00003000, 32'h12345678, 32'h0,        32'h0,        32'h0,        2,  99, 1'b1, 1'b0, 32'h00003000, 4'hF,  32'h12345678, 2, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd1, 5'd0,  32'h00003002, 32'h0000BEEF, 32'h0,        32'h0,        32'h0,        1,  99, 1'b1, 1'b0, 32'h00003000, 4'hC,  32'hBEEFBEEF, 1, 1'b0, 32'h0};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 3'd1, 5'd10, 32'h00004000, 32'h0,        32'h0,        32'h0,        32'h12348765, 1,  3,  1'b1, 1'b0, 32'h00004000, 4'h0,  32'h0,        3, 1'b1, 32'hFFFF8765};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 3'd4, 5'd11, 32'h00004001, 32'h0,        32'h0,        32'h0,        32'h0000F000, 0,  2,  1'b1, 1'b0, 32'h00004000, 4'h0,  32'h0,        2, 1'b1, 32'h000000F0};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 3'd2, 5'd12, 32'h00004004, 32'h0,        32'h0,        32'h0,        32'hDEADBEEF, 2,  4,  1'b1, 1'b0, 32'h00004004, 4'h0,  32'h0,        4, 1'b1, 32'hDEADBEEF};
    vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 3'd3, 5'd12, 32'h00004000, 32'h0,        32'h0,        32'h0,        32'h0,        99, 99, 1'b0, 1'b1, 32'h0,        4'h0,  32'h0,        0, 1'b0, 32'h0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 5'd0,  32'h00005000, 32'h00000042, 32'h0,        32'h0,        32'h0,        0,  99, 1'b1, 1'b0, 32'h00005000, 4'h1,  32'h42424242, 0, 1'b0, 32'h0};
    vt[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd0, 5'd13, 32'h00000ABC, 32'h0,        32'h0,        32'hFFFFF000, 32'h0,        99, 99, 1'b0, 1'b0, 32'h0,        4'h0,  32'h0,        0, 1'b1, 32'hFFFFF000};
    vt[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 3'd0, 5'd14, 32'h00000ABC, 32'h0,        32'h00000104, 32'h0,        32'h0,        99, 99, 1'b0, 1'b0, 32'h0,        4'h0,  32'h0,        0, 1'b1, 32'h00000104};
    vt[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 5'd15, 32'h00000055, 32'h0,        32'h0,        32'h0,        32'h0,        99, 99, 1'b0, 1'b0, 32'h0,        4'h0,  32'h0,        0, 1'b0, 32'h0};
    vt[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd1, 5'd0,  32'h00003001, 32'h0000BEEF, 32'h0,        32'h0,        32'h0,        99, 99, 1'b0, 1'b1, 32'h0,        4'h0,  32'h0,        0, 1'b0, 32'h0};
    vt[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 3'd0, 5'd16, 32'h00002001, 32'h0,        32'h0,        32'h0,        32'h00007F00, 0,  1,  1'b1, 1'b0, 32'h00002000, 4'h0,  32'h0,        1, 1'b1, 32'h0000007F};

    reset = 1'b1;
    bubble_e();
    resultSrcE_i = 2'd0; memFunct3E_i = 3'd0; rdE_i = 5'd0;
    aluResultE_i = 32'h0; writeDataE_i = 32'h0; pcPlus4E_i = 32'h0; extendedImmE_i = 32'h0;
    dmemGnt_i = 1'b0; dmemRvalid_i = 1'b0; dmemRdata_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stallM_o}, 32'd0);
    chk("rst_req", {31'b0, dmemReq_o}, 32'd0);
    chk("rst_we", {31'b0, dmemWe_o}, 32'd0);
    chk("rst_addr", dmemAddr_o, 32'd0);
    chk("rst_wstrb", {28'b0, dmemWstrb_o}, 32'd0);
    chk("rst_wdata", dmemWdata_o, 32'd0);
    chk("rst_rfwe", {31'b0, regWriteEnM_o}, 32'd0);
    chk("rst_src", {30'b0, resultSrcM_o}, 32'd0);
    chk("rst_alu", aluResultM_o, 32'd0);
    chk("rst_rdata", memReadDataM_o, 32'd0);
    chk("rst_pc4", pcPlus4M_o, 32'd0);
    chk("rst_imm", extendedImmM_o, 32'd0);
    chk("rst_rd", {27'b0, rdM_o}, 32'd0);
    chk("rst_mis", {31'b0, misalignM_o}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 17; i++) apply(vt[i]);

    // Back-to-back: store granted on entry, load enters on that edge and requests next cycle.
    h = vt[11];
    h.alu = 32'h00006000;
    h.wd  = 32'h00000011;
    drive_e(h);
    @(posedge clk); #1;
    h = vt[9];
    h.alu = 32'h00006008;
    h.rd  = 5'd17;
    drive_e(h);
    dmemGnt_i = 1'b1;
    @(negedge clk);
    chk("b2b_st_stall", {31'b0, stallM_o}, 32'd0);
    chk("b2b_st_addr", dmemAddr_o, 32'h00006000);
    chk("b2b_st_we", {31'b0, dmemWe_o}, 32'd1);
    @(posedge clk); #1;
    sb_q.push_back('{rd: 5'd17, src: 2'd2, val: 32'hCAFEF00D});
    bubble_e();
    dmemRdata_i = 32'hCAFEF00D;
    @(negedge clk);
    chk("b2b_ld_req", {31'b0, dmemReq_o}, 32'd1);
    chk("b2b_ld_addr", dmemAddr_o, 32'h00006008);
    chk("b2b_ld_we", {31'b0, dmemWe_o}, 32'd0);
    chk("b2b_ld_stall", {31'b0, stallM_o}, 32'd1);
    @(posedge clk); #1;
    dmemGnt_i    = 1'b1;
    dmemRvalid_i = 1'b1;
    @(negedge clk);
    chk("b2b_ld_done", {31'b0, stallM_o}, 32'd0);
    @(posedge clk); #1;
    dmemGnt_i    = 1'b0;
    dmemRvalid_i = 1'b0;

    // Reset while waiting for a load response; the late response must be dropped.
    h = vt[9];
    h.alu = 32'h00007000;
    h.rd  = 5'd18;
    drive_e(h);
    @(posedge clk); #1;
    bubble_e();
    dmemGnt_i   = 1'b1;
    dmemRdata_i = 32'h00000001;
    @(negedge clk);
    chk("rw_gnt_stall", {31'b0, stallM_o}, 32'd1);
    @(posedge clk); #1;
    dmemGnt_i = 1'b0;
    @(negedge clk);
    chk("rw_wait_stall", {31'b0, stallM_o}, 32'd1);
    chk("rw_wait_req", {31'b0, dmemReq_o}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rw_rst_stall", {31'b0, stallM_o}, 32'd0);
    chk("rw_rst_rfwe", {31'b0, regWriteEnM_o}, 32'd0);
    chk("rw_rst_alu", aluResultM_o, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    dmemRvalid_i = 1'b1;
    @(negedge clk);
    chk("rw_late_stall", {31'b0, stallM_o}, 32'd0);
    chk("rw_late_rfwe", {31'b0, regWriteEnM_o}, 32'd0);
    chk("rw_late_req", {31'b0, dmemReq_o}, 32'd0);
    @(posedge clk); #1;
    dmemRvalid_i = 1'b0;

    // A load issued after the dropped response must still see its own response.
    apply(vt[3]);

    repeat (2) @(posedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
